// File: rtl/fb_fill_dma.sv
// fb_fill_dma: register-programmed framebuffer fill engine.
//
// The CPU programs a destination word address, a word count and a 16-bit fill
// value through four 32-bit I/O registers, then sets START. The engine issues
// one 16-bit SDRAM write per word to the arbiter. It keeps at most one write
// in flight and waits for the arbiter's ack before it advances to the next
// word.
//
// Ports
//   clk_i, rst_ni        system clock (rising edge), async active-low reset
//   io_write_valid_i     one-cycle register write strobe
//   io_read_valid_i      one-cycle register read strobe
//   io_addr_i[3:0]       byte offset; [3:2] = 0 DST, 1 LEN, 2 VALUE, 3 CTRL/STATUS
//   io_wdata_i[31:0]     register write data
//   io_rdata_o[31:0]     registered read data, valid the cycle after the strobe
//   sdram_wr             write request, high for the single accepted cycle
//   sdram_rdy            arbiter ready to accept a request
//   sdram_ack            one-cycle write-complete pulse
//   sdram_addr_x16       word address of the current write
//   sdram_wdata          data of the current write
//   sdram_wmask          byte enables, always both bytes
//   irq_o                done AND irq_en (level)
//   dbg_state            current FSM state (0 IDLE, 1 REQ, 2 WAIT_ACK)
//
// Handshake: a request is transferred in a cycle where sdram_wr and sdram_rdy
// are both high. sdram_wr is only ever driven in such a cycle. After that, no
// new request is made until sdram_ack has been seen in WAIT_ACK. Address and
// data do not change from REQ entry until that ack.
//
// CTRL write bits: 0 START, 1 CLR_DONE, 2 INC, 3 ABORT, 4 IRQ_EN.
// STATUS read: {27'b0, irq_en, inc, aborted, done, busy}.

module fb_fill_dma #(
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              io_write_valid_i,
    input  logic              io_read_valid_i,
    input  logic [3:0]        io_addr_i,
    input  logic [31:0]       io_wdata_i,
    output logic [31:0]       io_rdata_o,
    output logic              sdram_wr,
    input  logic              sdram_rdy,
    input  logic              sdram_ack,
    output logic [ADDR_W-1:0] sdram_addr_x16,
    output logic [15:0]       sdram_wdata,
    output logic [1:0]        sdram_wmask,
    output logic              irq_o,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Programming registers
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  len_q;
    logic [15:0]       value_q;
    logic              inc_q;
    logic              irq_en_q;
    logic              done_q;
    logic              aborted_q;
    logic              abort_pend_q;

    // Working counters; address and data drive the SDRAM port directly
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [CNT_W-1:0]  rem_q;

    // Register write decode
    logic wr_dst, wr_len, wr_value, wr_ctrl;
    logic busy;
    logic start, start_go, start_zero;
    logic clr_done, abort_now, abort_hit;
    logic ack_take, last_word, fin_done, fin_abort;
    logic [31:0] rd_mux;

    assign wr_dst   = io_write_valid_i && (io_addr_i[3:2] == 2'd0);
    assign wr_len   = io_write_valid_i && (io_addr_i[3:2] == 2'd1);
    assign wr_value = io_write_valid_i && (io_addr_i[3:2] == 2'd2);
    assign wr_ctrl  = io_write_valid_i && (io_addr_i[3:2] == 2'd3);

    assign busy       = (state_q != IDLE);
    assign start      = wr_ctrl && io_wdata_i[0] && !busy;
    assign start_go   = start && (len_q != '0);
    assign start_zero = start && (len_q == '0);
    assign clr_done   = wr_ctrl && io_wdata_i[1];
    assign abort_now  = wr_ctrl && io_wdata_i[3];

    // An abort written in the same cycle as the ack counts as pending.
    assign abort_hit = abort_pend_q || abort_now;

    assign ack_take  = (state_q == WAIT_ACK) && sdram_ack;
    assign last_word = (rem_q == CNT_W'(1));
    assign fin_done  = ack_take && last_word;
    // A finished transfer wins over a pending abort; in REQ the abort is immediate.
    assign fin_abort = (ack_take && !last_word && abort_hit) ||
                       ((state_q == REQ) && abort_now);

    assign sdram_addr_x16 = addr_q;
    assign sdram_wdata    = wdata_q;
    assign sdram_wmask    = 2'b11;
    assign irq_o          = done_q && irq_en_q;
    assign dbg_state      = state_q;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and request strobe
    always_comb begin
        state_d  = state_q;
        sdram_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (abort_now) begin
                    state_d = IDLE;
                end else if (sdram_rdy) begin
                    sdram_wr = 1'b1;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    if (last_word || abort_hit) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Programming registers and status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dst_q        <= '0;
            len_q        <= '0;
            value_q      <= '0;
            inc_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            if (wr_dst && !busy) begin
                dst_q <= io_wdata_i[ADDR_W-1:0];
            end
            if (wr_len && !busy) begin
                len_q <= io_wdata_i[CNT_W-1:0];
            end
            if (wr_value && !busy) begin
                value_q <= io_wdata_i[15:0];
            end
            if (wr_ctrl) begin
                irq_en_q <= io_wdata_i[4];
                if (!busy) begin
                    inc_q <= io_wdata_i[2];
                end
            end

            // START beats CLR_DONE in the same write.
            if (start_go) begin
                done_q <= 1'b0;
            end else if (start_zero || fin_done) begin
                done_q <= 1'b1;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end

            if (start_go) begin
                aborted_q <= 1'b0;
            end else if (fin_abort) begin
                aborted_q <= 1'b1;
            end

            if (state_d == IDLE) begin
                abort_pend_q <= 1'b0;
            end else if (abort_now && (state_q == WAIT_ACK)) begin
                abort_pend_q <= 1'b1;
            end
        end
    end

    // Working counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rem_q   <= '0;
        end else if (start_go) begin
            addr_q  <= dst_q;
            wdata_q <= value_q;
            rem_q   <= len_q;
        end else if (ack_take) begin
            addr_q  <= addr_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            if (inc_q) begin
                wdata_q <= wdata_q + 16'd1;
            end
        end
    end

    // Register read path
    always_comb begin
        rd_mux = '0;
        case (io_addr_i[3:2])
            2'd0:    rd_mux = 32'(dst_q);
            2'd1:    rd_mux = 32'(len_q);
            2'd2:    rd_mux = {16'd0, value_q};
            default: rd_mux = {27'd0, irq_en_q, inc_q, aborted_q, done_q, busy};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_rdata_o <= '0;
        end else if (io_read_valid_i) begin
            io_rdata_o <= rd_mux;
        end
    end

    // Byte-offset low bits and upper write-data bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{io_addr_i[1:0], io_wdata_i};

endmodule

// File: doc/fb_fill_dma.md
FB_FILL_DMA -- requirements
Module: fb_fill_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, SDRAM word-address width (x16 words).
REQ-002 SHALL have parameter CNT_W, default 16, transfer word-count width.
REQ-003 SHALL have port clk_i  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port io_write_valid_i  in  1  one-cycle register-write strobe.
REQ-006 SHALL have port io_read_valid_i  in  1  one-cycle register-read strobe.
REQ-007 SHALL have port io_addr_i  in  4  byte offset; bits [3:2] select the register.
REQ-008 SHALL have port io_wdata_i  in  32  register write data.
REQ-009 SHALL have port io_rdata_o  out  32  register read data, registered.
REQ-010 SHALL have port sdram_wr  out  1  write request strobe to arbiter.
REQ-011 SHALL have port sdram_rdy  in  1  arbiter ready to accept a request.
REQ-012 SHALL have port sdram_ack  in  1  one-cycle write-complete pulse.
REQ-013 SHALL have port sdram_addr_x16  out  ADDR_W  word address.
REQ-014 SHALL have port sdram_wdata  out  16  write data.
REQ-015 SHALL have port sdram_wmask  out  2  byte enables; constant 2'b11.
REQ-016 SHALL have port irq_o  out  1  completion interrupt, level.

Function
REQ-017 SHALL decode registers: 0=DST[ADDR_W-1:0], 1=LEN[CNT_W-1:0], 2=VALUE[15:0], 3=CTRL/STATUS.
REQ-018 CTRL write bits SHALL be: 0 START, 1 CLR_DONE, 2 INC (value+1 per word), 3 ABORT, 4 IRQ_EN.
REQ-019 STATUS read SHALL return {27'b0, irq_en, inc, aborted, done, busy} at bits [4:0].
REQ-020 io_rdata_o SHALL present the addressed register one cycle after io_read_valid_i; unread bits zero.
REQ-021 Writes to DST, LEN, VALUE, INC SHALL be ignored while busy; IRQ_EN, CLR_DONE, ABORT always honoured.
REQ-022 FSM states SHALL be IDLE, REQ, WAIT_ACK.
REQ-023 In IDLE, START with LEN!=0 SHALL latch DST/LEN/VALUE into working counters, clear done and aborted, enter REQ next cycle.
REQ-024 START with LEN==0 SHALL set done, issue no SDRAM access, and stay IDLE.
REQ-025 START while busy SHALL be ignored.
REQ-026 In REQ, sdram_wr SHALL be 1 exactly in the first cycle sdram_rdy=1; FSM then enters WAIT_ACK.
REQ-027 sdram_addr_x16 and sdram_wdata SHALL be stable from REQ entry until sdram_ack.
REQ-028 sdram_ack outside WAIT_ACK SHALL be ignored.
REQ-029 On sdram_ack in WAIT_ACK: address +1 (wraps modulo 2^ADDR_W), remaining -1, data +1 mod 2^16 if INC.
REQ-030 After that ack: remaining reaching 0 SHALL set done and go IDLE; a pending abort SHALL set aborted and go IDLE; otherwise REQ.
REQ-031 ABORT in REQ SHALL go IDLE next cycle with aborted=1, no sdram_wr; ABORT in WAIT_ACK SHALL wait for the outstanding ack.
REQ-032 busy SHALL be 1 in REQ and WAIT_ACK, else 0.
REQ-033 Simultaneous START and CLR_DONE in one write SHALL start, leaving done=0.
REQ-034 irq_o SHALL equal done AND irq_en, combinational from registers.
REQ-035 sdram_wr SHALL never be asserted while a previous write is unacknowledged.

Reset
REQ-036 While rst_ni=0: state IDLE, all registers, counters, done, aborted, irq_en, inc, io_rdata_o, sdram_wr, sdram_addr_x16, sdram_wdata = 0; sdram_wmask = 2'b11; irq_o = 0.
REQ-037 Reset mid-transfer SHALL abandon it immediately; a later ack SHALL be ignored.

Verification
REQ-038 DST=0x000100, LEN=4, VALUE=0xABCD, START, rdy=1, ack 3 cycles after each wr -> writes 0x100..0x103 all 0xABCD, done=1, busy=0.
REQ-039 INC=1, DST=0xFFFFFE, LEN=3, VALUE=0xFFFF -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000; data 0xFFFF, 0x0000, 0x0001.
REQ-040 LEN=0, START -> no sdram_wr, done=1 next cycle; with IRQ_EN=1 irq_o=1; CLR_DONE -> irq_o=0.
REQ-041 LEN=10, ABORT during WAIT_ACK of word 3 -> exactly 3 writes completed, aborted=1, done=0.
REQ-042 sdram_rdy held 0 for 20 cycles in REQ -> sdram_wr stays 0, address/data stable, single wr when rdy rises.
REQ-043 Write DST=0x5 while busy, then read DST -> original DST returned; rst_ni pulsed mid-transfer -> all outputs zero, wmask 2'b11.
